// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: FIFO-buffered UART transmitter. Words go out LSB first, and frames are sent back-to-back.
// Define SERIAL_TX_PARITY_EN to add a parity bit after the data bits and the parity_odd input.
module serial_tx_fifo #(
  parameter int unsigned CLK_PER_BIT = 50,
  parameter int unsigned CTR_SIZE    = 6,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 new_data,
  output logic                 full,
  output logic [FIFO_AW:0]     level,
  input  logic                 block,
`ifdef SERIAL_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 busy,
  output logic                 tx
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned BCW   = $clog2(DATA_BITS + 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state, state_n;
  logic [CTR_SIZE-1:0]    timer, timer_n;
  logic [BCW-1:0]         bit_ctr, bit_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]          level_n;
  logic                   block_q;
  logic                   tx_n;
  logic                   busy_n;
  logic                   pop;
  logic                   push;
  logic                   tick;
  logic                   can_pop;
`ifdef SERIAL_TX_PARITY_EN
  logic                   par_q;
`endif

  assign push    = new_data && !full;
  assign tick    = (timer == CTR_SIZE'(CLK_PER_BIT - 1));
  assign can_pop = (level != '0) && !block_q;

  // Next-state, bit timing and line value; tx is the registered copy of tx_n
  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_ctr;
    shreg_n = shreg;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_n = START;
          timer_n = '0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (tick) begin
          state_n = DATA;
          timer_n = '0;
          bit_n   = '0;
        end else begin
          timer_n = timer + CTR_SIZE'(1);
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (tick) begin
          timer_n = '0;
          shreg_n = shreg >> 1;
          if (bit_ctr == BCW'(DATA_BITS - 1)) begin
            bit_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_ctr + BCW'(1);
          end
        end else begin
          timer_n = timer + CTR_SIZE'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        tx_n = par_q;
        if (tick) begin
          state_n = STOP;
          timer_n = '0;
          bit_n   = '0;
        end else begin
          timer_n = timer + CTR_SIZE'(1);
        end
      end
`endif
      STOP: begin
        if (tick) begin
          timer_n = '0;
          if (bit_ctr == BCW'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (can_pop) begin
              pop     = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_ctr + BCW'(1);
          end
        end else begin
          timer_n = timer + CTR_SIZE'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) shreg_n = mem[rd_ptr];
  end

  // busy mirrors the post-edge state/level/block_q so it always agrees with level
  assign level_n = level + LW'(push) - LW'(pop);
  assign busy_n  = (state_n != IDLE) || (level_n != '0) || block;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_ctr <= '0;
      shreg   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      busy    <= 1'b0;
      tx      <= 1'b1;
      block_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_ctr <= bit_n;
      shreg   <= shreg_n;
      level   <= level_n;
      full    <= (level_n == LW'(DEPTH));
      busy    <= busy_n;
      tx      <= tx_n;
      block_q <= block;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
`ifdef SERIAL_TX_PARITY_EN
      if (pop)  par_q  <= (^mem[rd_ptr]) ^ parity_odd;
`endif
    end
  end

  // FIFO storage needs no reset; level alone says which entries are valid
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= data;
  end

endmodule
